// File: rtl/uart_rx_fifo_if.sv
// Receiver/transmitter-side signal bundle for uart_rx_fifo; the slave modport is the FIFO's view.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_rx_dv;
  logic [7:0]    i_rx_byte;
  logic          i_tx_active;
  logic          i_tx_done;
  logic          o_tx_dv;
  logic [7:0]    o_tx_byte;
  logic [7:0]    o_last_byte;
  logic [CW-1:0] o_count;
  logic          o_empty;
  logic          o_full;
  logic          o_overflow;
  logic [7:0]    o_drop_cnt;

  modport master (
    output i_rx_dv, i_rx_byte, i_tx_active, i_tx_done,
    input  o_tx_dv, o_tx_byte, o_last_byte, o_count, o_empty, o_full, o_overflow, o_drop_cnt
  );

  modport slave (
    input  i_rx_dv, i_rx_byte, i_tx_active, i_tx_done,
    output o_tx_dv, o_tx_byte, o_last_byte, o_count, o_empty, o_full, o_overflow, o_drop_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO + one-frame-at-a-time TX launcher; launch one cycle after non-empty & TX idle, all outputs registered.
// A full FIFO drops incoming bytes (sticky o_overflow); UART_FIFO_DROP_CNT_EN adds a saturating drop counter.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          pop, push, drop;
  logic          tx_dv_q, empty_q, full_q, ovf_q;
  logic [7:0]    tx_byte_q, last_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && !bus.i_tx_active) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      // A done before active means the transmitter never reported busy; don't wait forever.
      LAUNCH: begin
        if (bus.i_tx_done)
          state_d = IDLE;
        else if (bus.i_tx_active)
          state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i_tx_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    push    = bus.i_rx_dv && ((count_q != FULL_CNT) || pop);
    drop    = bus.i_rx_dv && !push;
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      last_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_CNT);
      tx_dv_q <= pop;
      if (push) begin
        wptr_q <= wptr_q + PTR_ONE;
        last_q <= bus.i_rx_byte;
      end
      if (pop) begin
        rptr_q    <= rptr_q + PTR_ONE;
        tx_byte_q <= mem[rptr_q];
      end
      if (drop)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wptr_q] <= bus.i_rx_byte;
  end

`ifdef UART_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      drop_cnt_q <= 8'h00;
    else if (drop && (drop_cnt_q != 8'hFF))
      drop_cnt_q <= drop_cnt_q + 8'd1;
  end

  assign bus.o_drop_cnt = drop_cnt_q;
`else
  assign bus.o_drop_cnt = 8'h00;
`endif

  assign bus.o_tx_dv     = tx_dv_q;
  assign bus.o_tx_byte   = tx_byte_q;
  assign bus.o_last_byte = last_q;
  assign bus.o_count     = count_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_full      = full_q;
  assign bus.o_overflow  = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a behavioural UART transmitter and a launch monitor.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
`ifdef UART_FIFO_DROP_CNT_EN
  localparam int DROP_EXP = 2;
`else
  localparam int DROP_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();
  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       tx_stuck = 1'b0;
  int         frame_len = 4;
  int         busy_cnt = 0;
  logic [7:0] launched[$];
  int         done_cyc = -10;
  int         gap_bad = 0;
  int         unstable = 0;
  int         dv_double = 0;
  logic       gap_check = 1'b0;
  logic       prev_dv = 1'b0;
  logic       in_frame = 1'b0;
  logic [7:0] cur_byte = 8'h00;

  // Transmitter model: busy for frame_len cycles after a launch, then a one-cycle done.
  initial begin
    bus.i_tx_active = 1'b0;
    bus.i_tx_done   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.i_tx_done = 1'b0;
      if (tx_stuck) begin
        bus.i_tx_active = 1'b1;
        busy_cnt = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.i_tx_active = 1'b0;
          bus.i_tx_done   = 1'b1;
        end
      end else if (bus.o_tx_dv) begin
        bus.i_tx_active = 1'b1;
        busy_cnt = frame_len;
      end else begin
        bus.i_tx_active = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        in_frame = 1'b0;
        prev_dv  = 1'b0;
      end else begin
        if (in_frame && !bus.o_tx_dv && (bus.o_tx_byte !== cur_byte))
          unstable++;
        if (bus.i_tx_done) begin
          done_cyc = cyc;
          in_frame = 1'b0;
        end
        if (bus.o_tx_dv) begin
          if (prev_dv)
            dv_double++;
          if (gap_check && (launched.size() > 0) && (cyc - done_cyc != 1))
            gap_bad++;
          launched.push_back(bus.o_tx_byte);
          cur_byte = bus.o_tx_byte;
          in_frame = 1'b1;
        end
        prev_dv = bus.o_tx_dv;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_rx_dv   = 1'b0;
    bus.i_rx_byte = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_rx_dv   = 1'b1;
      bus.i_rx_byte = first + 8'(i);
      if (spacing > 1) begin
        @(negedge clk);
        bus.i_rx_dv = 1'b0;
        repeat (spacing - 2) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.i_rx_dv = 1'b0;
  endtask

  task automatic wait_launches(input string tag, input int n, input int budget);
    int k = 0;
    while ((launched.size() < n) && (k < budget)) begin
      @(posedge clk);
      #4;
      k++;
    end
    chk(tag, launched.size(), n);
  endtask

  task automatic check_order(input string tag, input logic [7:0] first, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if ((i >= launched.size()) || (launched[i] !== first + 8'(i)))
        bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    bus.i_rx_dv   = 1'b0;
    bus.i_rx_byte = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_count",   32'(bus.o_count), 0);
    chk("rst_empty",   32'(bus.o_empty), 1);
    chk("rst_full",    32'(bus.o_full), 0);
    chk("rst_tx_dv",   32'(bus.o_tx_dv), 0);
    chk("rst_tx_byte", 32'(bus.o_tx_byte), 0);
    chk("rst_last",    32'(bus.o_last_byte), 0);
    chk("rst_ovf",     32'(bus.o_overflow), 0);
    chk("rst_drop",    32'(bus.o_drop_cnt), 0);
    rst_n = 1'b1;

    // Single byte into an idle path.
    @(negedge clk);
    bus.i_rx_dv   = 1'b1;
    bus.i_rx_byte = 8'hA5;
    @(posedge clk);
    #4;
    chk("single_count1", 32'(bus.o_count), 1);
    chk("single_empty0", 32'(bus.o_empty), 0);
    chk("single_last",   32'(bus.o_last_byte), 32'hA5);
    chk("single_nodv",   32'(bus.o_tx_dv), 0);
    @(negedge clk);
    bus.i_rx_dv = 1'b0;
    @(posedge clk);
    #4;
    chk("single_dv",     32'(bus.o_tx_dv), 1);
    chk("single_byte",   32'(bus.o_tx_byte), 32'hA5);
    chk("single_count0", 32'(bus.o_count), 0);
    chk("single_empty1", 32'(bus.o_empty), 1);
    @(posedge clk);
    #4;
    chk("single_dv_pulse", 32'(bus.o_tx_dv), 0);
    wait_launches("single_n", 1, 50);
    repeat (20) @(negedge clk);

    // Burst at 217-cycle bit periods (10-bit frames).
    launched.delete();
    frame_len = 2170;
    gap_check = 1'b1;
    push_bytes(8'h01, 5, 1);
    wait_launches("burst_n", 5, 5 * 2200 + 100);
    check_order("burst_order", 8'h01, 5);
    chk("burst_gap", gap_bad, 0);
    gap_check = 1'b0;
    repeat (2200) @(negedge clk);
    chk("burst_stable", unstable, 0);
    frame_len = 4;

    // Overflow with the transmitter held busy.
    do_reset();
    launched.delete();
    tx_stuck = 1'b1;
    repeat (2) @(negedge clk);
    push_bytes(8'h10, 18, 1);
    @(posedge clk);
    #4;
    chk("ovf_full",   32'(bus.o_full), 1);
    chk("ovf_count",  32'(bus.o_count), 16);
    chk("ovf_flag",   32'(bus.o_overflow), 1);
    chk("ovf_last",   32'(bus.o_last_byte), 32'h1F);
    chk("ovf_drop",   32'(bus.o_drop_cnt), DROP_EXP);
    chk("ovf_nolaunch", launched.size(), 0);
    tx_stuck = 1'b0;
    wait_launches("ovf_drain_n", 16, 400);
    check_order("ovf_order", 8'h10, 16);
    repeat (10) @(negedge clk);
    chk("ovf_drained_empty", 32'(bus.o_empty), 1);
    chk("ovf_sticky",        32'(bus.o_overflow), 1);

    // Push while full, coincident with the launch edge.
    do_reset();
    launched.delete();
    tx_stuck = 1'b1;
    repeat (2) @(negedge clk);
    push_bytes(8'h30, 16, 1);
    @(posedge clk);
    #4;
    chk("paf_full_before", 32'(bus.o_full), 1);
    @(negedge clk);
    tx_stuck = 1'b0;
    @(negedge clk);
    bus.i_rx_dv   = 1'b1;
    bus.i_rx_byte = 8'h77;
    @(posedge clk);
    #4;
    chk("paf_dv",    32'(bus.o_tx_dv), 1);
    chk("paf_byte",  32'(bus.o_tx_byte), 32'h30);
    chk("paf_count", 32'(bus.o_count), 16);
    chk("paf_full",  32'(bus.o_full), 1);
    chk("paf_ovf",   32'(bus.o_overflow), 0);
    chk("paf_last",  32'(bus.o_last_byte), 32'h77);
    @(negedge clk);
    bus.i_rx_dv = 1'b0;
    wait_launches("paf_drain_n", 17, 400);
    check_order("paf_order", 8'h30, 16);
    chk("paf_tail", (launched.size() > 16) ? 32'(launched[16]) : 32'hFFFF_FFFF, 32'h77);

    // Wrap: 40 bytes paced through a 16-entry FIFO.
    do_reset();
    launched.delete();
    push_bytes(8'h40, 40, 5);
    wait_launches("wrap_n", 40, 600);
    check_order("wrap_order", 8'h40, 40);
    chk("wrap_ovf",  32'(bus.o_overflow), 0);
    chk("wrap_drop", 32'(bus.o_drop_cnt), 0);
    repeat (20) @(negedge clk);
    chk("wrap_empty", 32'(bus.o_empty), 1);

    // Asynchronous reset mid-frame with bytes queued.
    launched.delete();
    frame_len = 60;
    push_bytes(8'h80, 4, 1);
    repeat (5) @(posedge clk);
    #4;
    chk("mid_count",   32'(bus.o_count), 3);
    chk("mid_tx_byte", 32'(bus.o_tx_byte), 32'h80);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.o_count), 0);
    chk("mid_rst_empty", 32'(bus.o_empty), 1);
    chk("mid_rst_byte",  32'(bus.o_tx_byte), 0);
    chk("mid_rst_last",  32'(bus.o_last_byte), 0);
    chk("mid_rst_dv",    32'(bus.o_tx_dv), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #4;
    chk("mid_no_relaunch", launched.size(), 1);
    chk("mid_idle_empty",  32'(bus.o_empty), 1);
    frame_len = 4;
    push_bytes(8'hC3, 1, 1);
    wait_launches("mid_new_n", 2, 50);
    chk("mid_new_byte", (launched.size() > 1) ? 32'(launched[1]) : 32'hFFFF_FFFF, 32'hC3);
    chk("dv_never_double", dv_double, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
